// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter with credit-based FIFO flow control
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_pop,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [ADDR_WIDTH:0]           credits,
    output logic [$clog2(NUM_REQ)-1:0]    last_gnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             issue;

    // Scan offsets from the highest down so the smallest offset from rr_ptr is kept.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst && found && (credits != '0)) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign issue = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            credits    <= DEPTH_C;
            rr_ptr     <= '0;
            last_gnt   <= '0;
            fifo_wr    <= 1'b0;
            fifo_wdata <= '0;
        end else begin
            fifo_wr <= issue;
            if (issue) begin
                fifo_wdata <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                last_gnt   <= winner;
                rr_ptr     <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
            end
            // A pop into an already-empty FIFO model saturates rather than wrapping.
            case ({issue, fifo_pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   if (credits != DEPTH_C) credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    credit_overflow: assert property (@(posedge clk) disable iff (!rst)
        (fifo_pop && !issue) |-> (credits != DEPTH_C));

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one FIFO write port between NUM_REQ producers.
- Each producer uses a valid/ready handshake. The winner's data is forwarded to the FIFO through one registered stage: fifo_wr and fifo_wdata.
- An internal credit counter tracks free FIFO entries, so a write is never issued into a full FIFO despite the extra output latency.
- The block sits directly in front of the FIFO write side; the FIFO read side remains owned by the consumer.

Parameters:
- NUM_REQ, 4: number of requesters, range 2..8.
- DATA_WIDTH, 32: data word width.
- ADDR_WIDTH, 12: FIFO address width.
- DEPTH, 4096: FIFO capacity in entries; must be <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester write request.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant, combinational; data is accepted when valid&ready.
- fifo_pop  in  1  high for one cycle per entry actually removed by the consumer (rd && !empty).
- fifo_wr  out  1  registered write strobe to the FIFO.
- fifo_wdata  out  DATA_WIDTH  registered write data to the FIFO.
- credits  out  ADDR_WIDTH+1  free entries as seen by the arbiter.
- last_gnt  out  clog2(NUM_REQ)  index of the most recent winner.

Behaviour:
- Reset (rst==0 at a clk edge):
  - credits=DEPTH, rr_ptr=0, last_gnt=0, fifo_wr=0, fifo_wdata=0.
  - req_ready=0 for the whole cycle in which rst is low.
- Arbitration, evaluated every cycle:
  - The search starts at index rr_ptr and wraps modulo NUM_REQ.
  - The first i with req_valid[i]=1 wins.
  - req_ready[winner]=1 only if credits!=0; otherwise req_ready is all zero.
  - req_ready never has more than one bit set.
- Issue: issue = |(req_valid & req_ready).
  - On issue at edge T: fifo_wr=1 and fifo_wdata=req_data[winner] during cycle T+1.
  - Also on issue: last_gnt<=winner and rr_ptr<=(winner+1) mod NUM_REQ.
  - With no issue: fifo_wr<=0, fifo_wdata holds its value, rr_ptr holds.
- Latency: exactly 1 cycle from accepted handshake to fifo_wr. Sustained throughput is 1 write per cycle while credits>0.
- Credit arithmetic: credits <= credits - issue + fifo_pop, computed at width ADDR_WIDTH+1.
  - issue and fifo_pop in the same cycle: credits unchanged.
  - credits==0 with fifo_pop: no issue that cycle; credits becomes 1 and a grant is possible next cycle.
  - credits==DEPTH with fifo_pop and no issue is a protocol violation. Credits saturate at DEPTH; a simulation assertion fires.
  - credits never underflows, because a grant requires credits!=0.
- Fairness:
  - A requester holding valid is granted within NUM_REQ issue cycles.
  - The last winner has lowest priority on the next arbitration.
  - A lone requester is granted back-to-back.
- Requester rules:
  - req_data must be stable while req_valid=1 and not yet ready.
  - A requester may drop valid without having been granted; there is no lock.
  - req_ready is allowed to depend combinationally on req_valid.
- Reset mid-operation:
  - An in-flight registered write is discarded (fifo_wr=0 the next cycle).
  - Credits are reloaded to DEPTH; the FIFO must be reset in the same cycle.
- Invariant: credits + (FIFO occupancy) + fifo_wr == DEPTH at every edge after reset.

Test Plan:
- Reset, then all requesters valid, DEPTH=8, no pops -> grants follow the sequence 0,1,2,3,0,1,2,3. fifo_wr is high for 8 consecutive cycles, data arrives in grant order, then credits=0 and req_ready=0 while valid persists.
- FIFO full (credits=0), single fifo_pop pulse -> exactly one grant, one cycle after the pop. The grant goes to the requester after the last winner. credits returns to 0.
- Only requester 2 valid for 5 cycles -> req_ready[2]=1 in every cycle, 5 fifo_wr pulses, last_gnt=2.
- Simultaneous issue and fifo_pop every cycle at credits=3 -> credits stays at 3 throughout, with one write per cycle.
- rst driven low while fifo_wr is pending and credits=1 -> next cycle fifo_wr=0, credits=DEPTH, rr_ptr=0. After release, requester 0 wins first.
- Requesters 1 and 3 valid, requester 3 drops valid before being granted -> requester 1 is granted repeatedly. No req_ready ever asserts for 3, and no data from 3 reaches the FIFO.
